// File: rtl/enemy_bullet_pool_pkg.sv
// Shared game constants for the enemy bullet pool: coordinate widths, screen limits,
// the player hitbox and the per-channel state encoding.
package enemy_bullet_pool_pkg;
  localparam int N_CH          = 7;
  localparam int X_W           = 10;
  localparam int Y_W           = 9;
  localparam int SPEED         = 4;
  localparam int Y_LIMIT       = 480;
  localparam int PLAYER_Y      = 440;
  localparam int HIT_W         = 32;
  localparam int HIT_H         = 16;
  localparam int LIVES_INIT    = 3;
  localparam int LIVES_W       = 2;
  localparam int INVULN_FRAMES = 30;

  typedef enum logic {
    CH_IDLE   = 1'b0,
    CH_FLIGHT = 1'b1
  } ch_state_e;
endpackage

// File: rtl/enemy_bullet_pool_if.sv
// Bundle between the formation logic / renderer side (master) and the bullet pool (slave).
interface enemy_bullet_pool_if
  import enemy_bullet_pool_pkg::*;
#(
  parameter int P_N_CH    = N_CH,
  parameter int P_X_W     = X_W,
  parameter int P_Y_W     = Y_W,
  parameter int P_LIVES_W = LIVES_W
) ();
  logic [P_N_CH-1:0]       fire_req;
  logic [P_N_CH*P_X_W-1:0] spawn_x;
  logic [P_N_CH*P_Y_W-1:0] spawn_y;
  logic [P_X_W-1:0]        player_x;
  logic [P_N_CH-1:0]       bullet_active;
  logic [P_N_CH*P_X_W-1:0] bullet_x;
  logic [P_N_CH*P_Y_W-1:0] bullet_y;
  logic                    hit;
  logic                    invuln;
  logic [P_LIVES_W-1:0]    lives;
  logic                    lose;

  modport master (
    output fire_req, spawn_x, spawn_y, player_x,
    input  bullet_active, bullet_x, bullet_y, hit, invuln, lives, lose
  );

  modport slave (
    input  fire_req, spawn_x, spawn_y, player_x,
    output bullet_active, bullet_x, bullet_y, hit, invuln, lives, lose
  );
endinterface

// File: rtl/enemy_bullet_pool_bullet_channel.sv
// One falling enemy bullet: IDLE/FLIGHT state, position registers, step/retire
// and the hitbox compare against the registered position.
module bullet_channel
  import enemy_bullet_pool_pkg::*;
#(
  parameter int X_W      = enemy_bullet_pool_pkg::X_W,
  parameter int Y_W      = enemy_bullet_pool_pkg::Y_W,
  parameter int SPEED    = enemy_bullet_pool_pkg::SPEED,
  parameter int Y_LIMIT  = enemy_bullet_pool_pkg::Y_LIMIT,
  parameter int PLAYER_Y = enemy_bullet_pool_pkg::PLAYER_Y,
  parameter int HIT_W    = enemy_bullet_pool_pkg::HIT_W,
  parameter int HIT_H    = enemy_bullet_pool_pkg::HIT_H
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           fire_i,
  input  logic [X_W-1:0] spawn_x_i,
  input  logic [Y_W-1:0] spawn_y_i,
  input  logic [X_W-1:0] player_x_i,
  input  logic           retire_hit_i,
  input  logic           kill_i,
  output logic           active_o,
  output logic [X_W-1:0] x_o,
  output logic [Y_W-1:0] y_o,
  output logic           hit_o
);
  localparam logic [Y_W:0] Y_LIM = (Y_W+1)'(Y_LIMIT);
  localparam logic [Y_W:0] Y_TOP = (Y_W+1)'(PLAYER_Y);
  localparam logic [Y_W:0] Y_BOT = (Y_W+1)'(PLAYER_Y + HIT_H);

  ch_state_e      state_q, state_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [Y_W:0]   y_step;
  logic [X_W:0]   x_right;

  // One extra bit keeps the step and the hitbox right edge from wrapping.
  assign y_step  = {1'b0, y_q} + (Y_W+1)'(SPEED);
  assign x_right = {1'b0, player_x_i} + (X_W+1)'(HIT_W);

  assign hit_o = (state_q == CH_FLIGHT) &&
                 ({1'b0, x_q} >= {1'b0, player_x_i}) && ({1'b0, x_q} < x_right) &&
                 ({1'b0, y_q} >= Y_TOP) && ({1'b0, y_q} < Y_BOT);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    if (kill_i) begin
      state_d = CH_IDLE;
    end else begin
      case (state_q)
        CH_IDLE: begin
          if (fire_i) begin
            state_d = CH_FLIGHT;
            x_d     = spawn_x_i;
            y_d     = spawn_y_i;
          end
        end
        CH_FLIGHT: begin
          if ((retire_hit_i && hit_o) || (y_step >= Y_LIM)) begin
            state_d = CH_IDLE;
          end else begin
            y_d = y_step[Y_W-1:0];
          end
        end
        default: state_d = CH_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= CH_IDLE;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign active_o = (state_q == CH_FLIGHT);
  assign x_o      = x_q;
  assign y_o      = y_q;
endmodule

// File: rtl/enemy_bullet_pool.sv
// Enemy bullet pool: N_CH bullet channels plus the lives counter, post-hit
// invulnerability window and sticky lose flag.
module enemy_bullet_pool
  import enemy_bullet_pool_pkg::*;
#(
  parameter int N_CH          = enemy_bullet_pool_pkg::N_CH,
  parameter int X_W           = enemy_bullet_pool_pkg::X_W,
  parameter int Y_W           = enemy_bullet_pool_pkg::Y_W,
  parameter int SPEED         = enemy_bullet_pool_pkg::SPEED,
  parameter int Y_LIMIT       = enemy_bullet_pool_pkg::Y_LIMIT,
  parameter int PLAYER_Y      = enemy_bullet_pool_pkg::PLAYER_Y,
  parameter int HIT_W         = enemy_bullet_pool_pkg::HIT_W,
  parameter int HIT_H         = enemy_bullet_pool_pkg::HIT_H,
  parameter int LIVES_INIT    = enemy_bullet_pool_pkg::LIVES_INIT,
  parameter int LIVES_W       = enemy_bullet_pool_pkg::LIVES_W,
  parameter int INVULN_FRAMES = enemy_bullet_pool_pkg::INVULN_FRAMES
) (
  input  logic                 clk_30hz,
  input  logic                 rst,
  enemy_bullet_pool_if.slave   bus
);
  localparam int INV_W = $clog2(INVULN_FRAMES + 1);

  logic [N_CH-1:0]    active_w;
  logic [N_CH-1:0]    hit_w;
  logic [X_W-1:0]     x_w [N_CH];
  logic [Y_W-1:0]     y_w [N_CH];

  logic               hit_q, hit_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [INV_W-1:0]   inv_q, inv_d;
  logic               lose_q, lose_d;
  logic               accept, lose_set, kill;

  // A hit only counts outside the invulnerability window and before game over.
  assign accept   = (|hit_w) && (inv_q == '0) && !lose_q;
  assign lose_set = accept && (lives_q == LIVES_W'(1));
  assign kill     = lose_q || lose_set;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    bullet_channel #(
      .X_W(X_W), .Y_W(Y_W), .SPEED(SPEED), .Y_LIMIT(Y_LIMIT),
      .PLAYER_Y(PLAYER_Y), .HIT_W(HIT_W), .HIT_H(HIT_H)
    ) u_ch (
      .clk_i       (clk_30hz),
      .rst_i       (rst),
      .fire_i      (bus.fire_req[g]),
      .spawn_x_i   (bus.spawn_x[g*X_W +: X_W]),
      .spawn_y_i   (bus.spawn_y[g*Y_W +: Y_W]),
      .player_x_i  (bus.player_x),
      .retire_hit_i(accept),
      .kill_i      (kill),
      .active_o    (active_w[g]),
      .x_o         (x_w[g]),
      .y_o         (y_w[g]),
      .hit_o       (hit_w[g])
    );
  end

  always_comb begin
    hit_d   = accept;
    lives_d = lives_q;
    lose_d  = lose_q || lose_set;
    inv_d   = inv_q;
    if (accept && (lives_q != '0)) begin
      lives_d = lives_q - LIVES_W'(1);
    end
    if (accept) begin
      inv_d = INV_W'(INVULN_FRAMES);
    end else if (inv_q != '0) begin
      inv_d = inv_q - INV_W'(1);
    end
  end

  always_ff @(posedge clk_30hz or posedge rst) begin
    if (rst) begin
      hit_q   <= 1'b0;
      lives_q <= LIVES_W'(LIVES_INIT);
      inv_q   <= '0;
      lose_q  <= 1'b0;
    end else begin
      hit_q   <= hit_d;
      lives_q <= lives_d;
      inv_q   <= inv_d;
      lose_q  <= lose_d;
    end
  end

  always_comb begin
    bus.bullet_x = '0;
    bus.bullet_y = '0;
    for (int i = 0; i < N_CH; i++) begin
      bus.bullet_x[i*X_W +: X_W] = x_w[i];
      bus.bullet_y[i*Y_W +: Y_W] = y_w[i];
    end
  end

  assign bus.bullet_active = active_w;
  assign bus.hit           = hit_q;
  assign bus.invuln        = (inv_q != '0);
  assign bus.lives         = lives_q;
  assign bus.lose          = lose_q;
endmodule
